// File: rtl/sa_out_deskew.sv
// sa_out_deskew: realigns the diagonally skewed output of a systolic array
// into whole rows, queues them in a small first-word-fall-through row FIFO
// and hands them to a consumer with a valid/ready handshake.
module sa_out_deskew #(
    parameter int D_W   = 8,
    parameter int N     = 64,
    parameter int X_R   = 64,
    parameter int LAT   = 0,
    parameter int DEPTH = 4,
    localparam int IDX_W = (X_R > 1) ? $clog2(X_R) : 1
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_START_FLAG,
    input  logic               I_VLD,
    input  logic [N*D_W-1:0]   I_DATA,
    output logic               O_ROW_VLD,
    input  logic               I_ROW_RDY,
    output logic [N*D_W-1:0]   O_ROW,
    output logic [IDX_W-1:0]   O_ROW_IDX,
    output logic               O_DONE,
    output logic               O_OVF
);

    localparam int BCNT_W = $clog2(X_R + N + LAT + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    // Beat at which row 0 is fully aligned, beat that aligns the last row,
    // and the value the beat counter parks at.
    localparam logic [BCNT_W-1:0] FIRST_B  = BCNT_W'(N - 1 + LAT);
    localparam logic [BCNT_W-1:0] LAST_B   = BCNT_W'(N - 1 + LAT + X_R - 1);
    localparam logic [BCNT_W-1:0] BEAT_MAX = BCNT_W'(X_R + N + LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BCNT_W-1:0]  beatCnt_q;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [N*D_W-1:0]   rowMem_q [DEPTH];
    logic [IDX_W-1:0]   idxMem_q [DEPTH];

    logic               beatAcc;
    logic               inWindow;
    logic               pushReq;
    logic               fifoFull;
    logic               rowVld;
    logic               doPush;
    logic               doPop;
    logic               dropRow;
    logic [IDX_W-1:0]   rowIdx;
    logic [N*D_W-1:0]   alignedRow;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A start in the same cycle wins over the beat, which is then discarded.
    assign beatAcc  = (state_q == S_RUN) && I_VLD && !I_START_FLAG;
    assign inWindow = (beatCnt_q >= FIRST_B) && (beatCnt_q <= LAST_B);
    assign pushReq  = beatAcc && inWindow;
    assign fifoFull = (count_q == CNT_W'(DEPTH));
    assign rowVld   = (count_q != '0);
    assign doPop    = rowVld && I_ROW_RDY && !I_START_FLAG;
    assign doPush   = pushReq && (!fifoFull || doPop);
    assign dropRow  = pushReq && fifoFull && !doPop;
    assign rowIdx   = IDX_W'(beatCnt_q - FIRST_B);

    // The rightmost lane is already the latest one and needs no delay.
    assign alignedRow[(N-1)*D_W +: D_W] = I_DATA[(N-1)*D_W +: D_W];

    for (genvar c = 0; c < N - 1; c++) begin : g_lane
        localparam int L = N - 1 - c;
        logic [D_W-1:0] skew_q [L];

        // Per-lane delay line of N-1-c stages, stepping only on accepted beats.
        always_ff @(posedge I_CLK) begin
            if (I_RST || I_START_FLAG) begin
                for (int k = 0; k < L; k++) skew_q[k] <= '0;
            end else if (beatAcc) begin
                skew_q[0] <= I_DATA[c*D_W +: D_W];
                for (int k = 1; k < L; k++) skew_q[k] <= skew_q[k-1];
            end
        end

        assign alignedRow[c*D_W +: D_W] = skew_q[L-1];
    end

    // Beat counter: counts accepted beats of the current job and parks at its top value.
    always_ff @(posedge I_CLK) begin
        if (I_RST || I_START_FLAG) begin
            beatCnt_q <= '0;
        end else if (beatAcc && (beatCnt_q != BEAT_MAX)) begin
            beatCnt_q <= beatCnt_q + BCNT_W'(1);
        end
    end

    // FIFO bookkeeping: a start flushes the queue and clears the overflow flag.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (I_START_FLAG) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (doPush) wrPtr_d = nextPtr(wrPtr_q);
            if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
            if (doPush && !doPop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!doPush && doPop) begin
                count_d = count_q - CNT_W'(1);
            end
            if (dropRow) ovf_d = 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Row storage; contents are only visible through the valid-gated outputs.
    always_ff @(posedge I_CLK) begin
        if (doPush && !I_RST) begin
            rowMem_q[wrPtr_q] <= alignedRow;
            idxMem_q[wrPtr_q] <= rowIdx;
        end
    end

    // Job state register.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job sequencing; drain ends the moment the queue becomes empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (beatAcc && (beatCnt_q == LAST_B)) state_d = S_DRAIN;
            S_DRAIN: if (count_d == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (I_START_FLAG) state_d = S_RUN;
    end

    assign O_ROW_VLD = rowVld;
    assign O_ROW     = rowVld ? rowMem_q[rdPtr_q] : '0;
    assign O_ROW_IDX = rowVld ? idxMem_q[rdPtr_q] : '0;
    assign O_DONE    = (state_q == S_DONE);
    assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_sa_out_deskew.sv
// Directed bench for sa_out_deskew with a 4-lane, 3-row, depth-2 configuration.
// Element (r,c) carries 16r+c; lanes outside the valid diagonal carry 0xEE.
module tb_sa_out_deskew;

    localparam int D_W   = 8;
    localparam int N     = 4;
    localparam int X_R   = 3;
    localparam int LAT   = 0;
    localparam int DEPTH = 2;
    localparam int IDX_W = 2;

    logic               I_CLK = 1'b0;
    logic               I_RST = 1'b1;
    logic               I_START_FLAG = 1'b0;
    logic               I_VLD = 1'b0;
    logic [N*D_W-1:0]   I_DATA = '0;
    logic               O_ROW_VLD;
    logic               I_ROW_RDY = 1'b0;
    logic [N*D_W-1:0]   O_ROW;
    logic [IDX_W-1:0]   O_ROW_IDX;
    logic               O_DONE;
    logic               O_OVF;

    int vecCount  = 0;
    int missCount = 0;

    // Free-running clock.
    always #5 I_CLK = ~I_CLK;

    sa_out_deskew #(
        .D_W   (D_W),
        .N     (N),
        .X_R   (X_R),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .I_CLK        (I_CLK),
        .I_RST        (I_RST),
        .I_START_FLAG (I_START_FLAG),
        .I_VLD        (I_VLD),
        .I_DATA       (I_DATA),
        .O_ROW_VLD    (O_ROW_VLD),
        .I_ROW_RDY    (I_ROW_RDY),
        .O_ROW        (O_ROW),
        .O_ROW_IDX    (O_ROW_IDX),
        .O_DONE       (O_DONE),
        .O_OVF        (O_OVF)
    );

    function automatic logic [31:0] beatData(input int b);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
            int r;
            r = b - c;
            if (r >= 0 && r < X_R) v[c*8 +: 8] = 8'(16 * r + c);
            else                   v[c*8 +: 8] = 8'hEE;
        end
        return v;
    endfunction

    function automatic logic [31:0] expRow(input int r);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[c*8 +: 8] = 8'(16 * r + c);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expVld, input logic [31:0] expRowV,
                            input int expIdx, input logic expDone, input logic expOvf);
        checkOutput({tag, ".vld"},  64'(O_ROW_VLD), 64'(expVld));
        checkOutput({tag, ".row"},  64'(O_ROW),     64'(expRowV));
        checkOutput({tag, ".idx"},  64'(O_ROW_IDX), 64'(expIdx));
        checkOutput({tag, ".done"}, 64'(O_DONE),    64'(expDone));
        checkOutput({tag, ".ovf"},  64'(O_OVF),     64'(expOvf));
    endtask

    task automatic applyStimulus(input logic rst, input logic start, input logic vld,
                                 input logic [31:0] data, input logic rdy);
        I_RST        = rst;
        I_START_FLAG = start;
        I_VLD        = vld;
        I_DATA       = data;
        I_ROW_RDY    = rdy;
        @(posedge I_CLK);
        #1;
    endtask

    // Start cycle carries a junk beat that must be discarded.
    task automatic startJob(input string tag);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b1);
        checkAll({tag, ".start"}, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    // Contiguous beats with a consumer that is always ready.
    task automatic cleanBeats(input string tag);
        for (int b = 0; b < 6; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b1);
            if (b >= 3) checkAll($sformatf("%s.b%0d", tag, b), 1'b1, expRow(b - 3), b - 3, 1'b0, 1'b0);
            else        checkAll($sformatf("%s.b%0d", tag, b), 1'b0, 32'h0, 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll({tag, ".done"}, 1'b0, 32'h0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll({tag, ".after"}, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    // Contiguous beats with the consumer stalled; row 2 lands on a full queue.
    task automatic stalledBeats(input string tag);
        for (int b = 0; b < 6; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b0);
            if (b >= 3) checkAll($sformatf("%s.b%0d", tag, b), 1'b1, expRow(0), 0, 1'b0, b == 5);
            else        checkAll($sformatf("%s.b%0d", tag, b), 1'b0, 32'h0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset state, and beats in IDLE are ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1);
        checkAll("reset", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b1);
            checkAll($sformatf("idle.b%0d", b), 1'b0, 32'h0, 0, 1'b0, 1'b0);
        end

        // Basic job.
        startJob("clean");
        cleanBeats("clean");

        // Every other cycle idle, carrying junk data.
        startJob("gap");
        for (int b = 0; b < 6; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b1);
            if (b >= 3) checkAll($sformatf("gap.b%0d", b), 1'b1, expRow(b - 3), b - 3, 1'b0, 1'b0);
            else        checkAll($sformatf("gap.b%0d", b), 1'b0, 32'h0, 0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
            checkAll($sformatf("gap.g%0d", b), 1'b0, 32'h0, 0, b == 5, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("gap.after", 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Consumer stalled throughout: row 2 dropped, rows 0 and 1 held.
        startJob("stall");
        stalledBeats("stall");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkAll($sformatf("stall.hold%0d", k), 1'b1, expRow(0), 0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("stall.pop0", 1'b1, expRow(1), 1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("stall.done", 1'b0, 32'h0, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("stall.after", 1'b0, 32'h0, 0, 1'b0, 1'b1);

        // Full queue with push and pop together: nothing dropped.
        startJob("full");
        for (int b = 0; b < 5; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b0);
            if (b >= 3) checkAll($sformatf("full.b%0d", b), 1'b1, expRow(0), 0, 1'b0, 1'b0);
            else        checkAll($sformatf("full.b%0d", b), 1'b0, 32'h0, 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, beatData(5), 1'b1);
        checkAll("full.b5", 1'b1, expRow(1), 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkAll("full.hold", 1'b1, expRow(1), 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("full.pop1", 1'b1, expRow(2), 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("full.done", 1'b0, 32'h0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkAll("full.after", 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Restart while draining with rows queued.
        startJob("rest");
        stalledBeats("rest");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkAll("rest.start", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        cleanBeats("rest.new");

        // Reset mid-job aborts it; later beats are ignored until a start.
        startJob("rst");
        for (int b = 0; b < 5; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b0);
        end
        checkAll("rst.pre", 1'b1, expRow(0), 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, beatData(5), 1'b1);
        checkAll("rst.pulse", 1'b0, 32'h0, 0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, beatData(b), 1'b1);
            checkAll($sformatf("rst.ign%0d", b), 1'b0, 32'h0, 0, 1'b0, 1'b0);
        end
        startJob("rst.new");
        cleanBeats("rst.new");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/sa_out_deskew.md
SA_OUT_DESKEW -- requirements
Module: sa_out_deskew

Interface
REQ-001 Parameters (name, default, meaning):
- D_W, 8, element width
- N, 64, systolic-array columns (lanes)
- X_R, 64, result rows per job
- LAT, 0, beats before element (0,0) appears on lane 0
- DEPTH, 4, row FIFO depth (>=2)

REQ-002 Ports (name, direction, width, meaning):
- I_CLK, in, 1, clock
- I_RST, in, 1, synchronous active-high reset
- I_START_FLAG, in, 1, job start; clears job state
- I_VLD, in, 1, array output beat valid (one per PE shift)
- I_DATA, in, N*D_W, skewed array output; lane c = bits [c*D_W +: D_W]
- O_ROW_VLD, out, 1, aligned row available
- I_ROW_RDY, in, 1, consumer accepts row
- O_ROW, out, N*D_W, aligned row; lane c = column c
- O_ROW_IDX, out, max(1,$clog2(X_R)), row index of O_ROW
- O_DONE, out, 1, one-cycle pulse when the job is fully drained
- O_OVF, out, 1, sticky: a row was dropped on a full FIFO

Function
REQ-003 Skew model: element (r,c) arrives on lane c at accepted beat b = r + c + LAT, with b counted from 0 after start.
REQ-004 Deskew: lane c passes through an (N-1-c)-stage shift register that advances only on beats with I_VLD=1; lane N-1 has no delay.
REQ-005 Aligned vector at beat b is row r = b-(N-1)-LAT; it is pushed into the FIFO only when 0 <= r < X_R, tagged with r.
REQ-006 Beat counter: width $clog2(X_R+N+LAT+1); increments on I_VLD only in RUN; saturates at its final value.
REQ-007 States:
- IDLE: I_VLD ignored.
- RUN: entered from any state on I_START_FLAG; that cycle clears the beat counter, skew registers, FIFO and O_OVF. RUN -> DRAIN after the beat pushing row X_R-1.
- DRAIN -> DONE when the FIFO is empty.
- DONE: O_DONE=1 for exactly one cycle -> IDLE.
REQ-008 I_START_FLAG has priority over I_VLD in the same cycle; that beat is discarded.
REQ-009 FIFO is first-word-fall-through: a row pushed at the beat in cycle t is on O_ROW with O_ROW_VLD=1 in cycle t+1 if the FIFO was empty.
REQ-010 Pop occurs when O_ROW_VLD & I_ROW_RDY; O_ROW and O_ROW_IDX stay stable while O_ROW_VLD=1 and I_ROW_RDY=0.
REQ-011 Full FIFO with a push and a pop in the same cycle: both succeed and occupancy is unchanged.
REQ-012 Full FIFO with a push and no pop: the row is dropped, O_OVF is set and held until reset or start, and the job still completes.
REQ-013 The upstream array cannot stall, so I_VLD has no ready; the block never back-pressures its input.
REQ-014 Data passes through unmodified: no arithmetic or width change.

Reset
REQ-015 With I_RST=1 at a clock edge: state=IDLE; beat counter, FIFO pointers and count are 0; O_ROW_VLD=0, O_DONE=0, O_OVF=0, O_ROW=0, O_ROW_IDX=0; skew registers are cleared.
REQ-016 Reset mid-job aborts it: no O_DONE is issued and queued rows are lost.

Verification (N=4, X_R=3, LAT=0, DEPTH=2, D_W=8, element (r,c) = 16r+c)
REQ-017 Start, then 6 contiguous skewed beats, I_ROW_RDY=1 -> rows 0,1,2 = {0x03,0x02,0x01,0x00}, {0x13,...,0x10}, {0x23,...,0x20}, IDX 0,1,2, appearing the cycle after beats 3,4,5; O_DONE one cycle after the last pop; O_OVF=0.
REQ-018 Same job with I_VLD low every other cycle -> identical rows and order; deskew is unaffected by gaps.
REQ-019 I_ROW_RDY=0 throughout -> rows 0 and 1 are held with O_ROW stable, row 2 is dropped, O_OVF=1; after RDY=1, rows 0 and 1 pop and O_DONE pulses.
REQ-020 FIFO full, push and pop in the same cycle -> no drop, O_OVF stays 0, count stays 2.
REQ-021 I_START_FLAG asserted in the DRAIN state with rows queued -> FIFO empties in the next cycle, O_ROW_VLD=0, no O_DONE, new job runs correctly.
REQ-022 I_RST pulsed after the beat for row 1 -> all outputs go to reset values next cycle; later I_VLD is ignored until start.
